sigma_rst_seq: RTL and testbench

SIGMA_RST_SEQ -- requirements
Module: sigma_rst_seq

---
 rtl/sigma_rst_seq.sv | 184 ++++++++++++++++++
 tb/tb_sigma_rst_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_rst_seq.sv
// sigma_rst_seq
// Reset sequencer and push-button debouncer for the system clock domain.
// Brings the peripherals out of reset once the PLL lock has been stable for
// LOCK_STABLE_CYCLES, releases the CPU PERIPH_TO_CPU_CYCLES later, and drops
// back into full reset whenever lock is lost. A debounced button press in RUN
// produces a single-cycle interrupt pulse.
//
// Ports
//   clk_i          system clock (PLL output)
//   arst_ni        asynchronous active-low reset
//   pll_locked_i   PLL lock, asynchronous to clk_i
//   btn_i          raw push-button, asynchronous, active-high
//   periph_arst_o  active-high reset for UART/GPIO/memory (registered)
//   cpu_arst_o     active-high reset for the CPU core (registered)
//   irq_btn_o      one-cycle debounced press pulse (registered)
//   state_o        current sequencer state (RESET=0 STABLE=1 PERIPH=2 RUN=3)
//   lock_lost_o    sticky: lock dropped while in RUN
module sigma_rst_seq #(
  parameter int unsigned LOCK_STABLE_CYCLES   = 1024,
  parameter int unsigned PERIPH_TO_CPU_CYCLES = 16,
  parameter int unsigned DEBOUNCE_CYCLES      = 100000
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic       pll_locked_i,
  input  logic       btn_i,
  output logic       periph_arst_o,
  output logic       cpu_arst_o,
  output logic       irq_btn_o,
  output logic [1:0] state_o,
  output logic       lock_lost_o
);

  localparam int unsigned FsmMax = (LOCK_STABLE_CYCLES > PERIPH_TO_CPU_CYCLES) ?
                                   LOCK_STABLE_CYCLES : PERIPH_TO_CPU_CYCLES;
  localparam int unsigned CntW   = (FsmMax > 1) ? $clog2(FsmMax) : 1;
  localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CntW-1:0] LockLast   = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] PeriphLast = CntW'(PERIPH_TO_CPU_CYCLES - 1);
  localparam logic [DbW-1:0]  DbLast     = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StReset  = 2'd0,
    StStable = 2'd1,
    StPeriph = 2'd2,
    StRun    = 2'd3
  } state_e;

  logic lock_meta_q, lock_s_q;
  logic btn_meta_q, btn_s_q;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            periph_q, cpu_q, lock_lost_q;

  logic            db_level_q, db_level_d;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  logic            db_rise;
  logic            irq_q, irq_d;

  // Two-flop synchronizers for the asynchronous lock and button inputs.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      btn_meta_q  <= 1'b0;
      btn_s_q     <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked_i;
      lock_s_q    <= lock_meta_q;
      btn_meta_q  <= btn_i;
      btn_s_q     <= btn_meta_q;
    end
  end

  // Debouncer: count consecutive samples that disagree with the accepted
  // level; after DEBOUNCE_CYCLES of them the level flips.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = db_cnt_q;
    db_rise    = 1'b0;
    if (btn_s_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      db_level_d = ~db_level_q;
      db_cnt_d   = '0;
      db_rise    = ~db_level_q;
    end else begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end
  end

  // A press only interrupts when the sequencer is in RUN and stays there on
  // this edge, so a press coinciding with a lock loss is dropped.
  assign irq_d = db_rise && (state_q == StRun) && lock_s_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      irq_q      <= irq_d;
    end
  end

  // Sequencer. The reset outputs are assigned together with the state so
  // they change on the very edge a state is entered, without decode glitches.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= StReset;
      cnt_q       <= '0;
      periph_q    <= 1'b1;
      cpu_q       <= 1'b1;
      lock_lost_q <= 1'b0;
    end else begin
      case (state_q)
        StReset: begin
          periph_q <= 1'b1;
          cpu_q    <= 1'b1;
          if (lock_s_q) begin
            state_q <= StStable;
            cnt_q   <= '0;
          end
        end
        StStable: begin
          if (!lock_s_q) begin
            state_q  <= StReset;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            cpu_q    <= 1'b1;
          end else if (cnt_q == LockLast) begin
            state_q  <= StPeriph;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            cpu_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StPeriph: begin
          if (!lock_s_q) begin
            state_q  <= StReset;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            cpu_q    <= 1'b1;
          end else if (cnt_q == PeriphLast) begin
            state_q  <= StRun;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            cpu_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRun: begin
          if (!lock_s_q) begin
            state_q     <= StReset;
            cnt_q       <= '0;
            periph_q    <= 1'b1;
            cpu_q       <= 1'b1;
            lock_lost_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= StReset;
          cnt_q    <= '0;
          periph_q <= 1'b1;
          cpu_q    <= 1'b1;
        end
      endcase
    end
  end

  assign periph_arst_o = periph_q;
  assign cpu_arst_o    = cpu_q;
  assign irq_btn_o     = irq_q;
  assign state_o       = state_q;
  assign lock_lost_o   = lock_lost_q;

endmodule

// File: tb/tb_sigma_rst_seq.sv
// tb_sigma_rst_seq
// Self-checking bench for sigma_rst_seq with small parameters. A reference
// model derives the expected outputs from the input history: the sequencer
// state follows from how long the synchronized lock has been continuously
// high, and the debounced level flips when the last DEBOUNCE_CYCLES
// synchronized button samples all disagree with it.
module tb_sigma_rst_seq;

  localparam int L = 8;
  localparam int P = 4;
  localparam int D = 5;

  logic       clk_i = 1'b0;
  logic       arst_ni;
  logic       pll_locked_i;
  logic       btn_i;
  logic       periph_arst_o;
  logic       cpu_arst_o;
  logic       irq_btn_o;
  logic [1:0] state_o;
  logic       lock_lost_o;

  sigma_rst_seq #(
    .LOCK_STABLE_CYCLES  (L),
    .PERIPH_TO_CPU_CYCLES(P),
    .DEBOUNCE_CYCLES     (D)
  ) dut (
    .clk_i        (clk_i),
    .arst_ni      (arst_ni),
    .pll_locked_i (pll_locked_i),
    .btn_i        (btn_i),
    .periph_arst_o(periph_arst_o),
    .cpu_arst_o   (cpu_arst_o),
    .irq_btn_o    (irq_btn_o),
    .state_o      (state_o),
    .lock_lost_o  (lock_lost_o)
  );

  always #5 clk_i = ~clk_i;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state.
  bit mPll[$];
  bit mBtn[$];
  bit mWin[$];
  int mRun;
  bit mLevel;
  bit mLost;
  bit mIrq;

  typedef struct {
    logic       lock;
    logic       btn;
    int         steps;
    logic [1:0] st;
    logic       periph;
    logic       cpu;
    logic       lost;
  } vec_t;

  vec_t tbl[$];

  function automatic int stateOf(input int k);
    if (k == 0)         return 0;
    else if (k <= L)    return 1;
    else if (k <= L + P) return 2;
    else                return 3;
  endfunction

  task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPll.delete();
    mBtn.delete();
    mWin.delete();
    mRun   = 0;
    mLevel = 1'b0;
    mLost  = 1'b0;
    mIrq   = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs sampled there.
  task automatic modelEdge(input bit lk, input bit bt);
    int  prevSt, newSt;
    bit  visL, visB, allDiffer, rise;
    prevSt = stateOf(mRun);
    mPll.push_back(lk);
    mBtn.push_back(bt);
    visL = (mPll.size() >= 3) ? mPll[mPll.size() - 3] : 1'b0;
    visB = (mBtn.size() >= 3) ? mBtn[mBtn.size() - 3] : 1'b0;
    if (mPll.size() > 4) void'(mPll.pop_front());
    if (mBtn.size() > 4) void'(mBtn.pop_front());
    if (visL) mRun = (mRun < 100000) ? mRun + 1 : mRun;
    else      mRun = 0;
    if (!visL && prevSt == 3) mLost = 1'b1;
    newSt = stateOf(mRun);
    mWin.push_back(visB);
    if (mWin.size() > D) void'(mWin.pop_front());
    rise = 1'b0;
    if (mWin.size() == D) begin
      allDiffer = 1'b1;
      foreach (mWin[i]) if (mWin[i] == mLevel) allDiffer = 1'b0;
      if (allDiffer) begin
        rise   = !mLevel;
        mLevel = !mLevel;
      end
    end
    mIrq = rise && prevSt == 3 && newSt == 3;
  endtask

  task automatic checkOutput();
    int st;
    st = stateOf(mRun);
    checkVal("state", 32'(state_o), 32'(st));
    checkVal("periph_arst", 32'(periph_arst_o), 32'(st < 2));
    checkVal("cpu_arst", 32'(cpu_arst_o), 32'(st < 3));
    checkVal("irq_btn", 32'(irq_btn_o), 32'(mIrq));
    checkVal("lock_lost", 32'(lock_lost_o), 32'(mLost));
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the
  // next falling edge.
  task automatic applyStimulus(input bit lk, input bit bt);
    pll_locked_i = lk;
    btn_i        = bt;
    @(posedge clk_i);
    modelEdge(lk, bt);
    @(negedge clk_i);
    checkOutput();
  endtask

  task automatic runSeq(input bit lk, input bit bt, input int n, output int pulses, output int firstAt);
    pulses  = 0;
    firstAt = 0;
    for (int i = 1; i <= n; i++) begin
      applyStimulus(lk, bt);
      if (irq_btn_o === 1'b1) begin
        pulses++;
        if (firstAt == 0) firstAt = i;
      end
    end
  endtask

  // Reset pulse lasting one clock; outputs must react before any edge.
  task automatic pulseReset();
    arst_ni = 1'b0;
    #1;
    checkVal("rst periph_arst", 32'(periph_arst_o), 32'd1);
    checkVal("rst cpu_arst", 32'(cpu_arst_o), 32'd1);
    checkVal("rst state", 32'(state_o), 32'd0);
    checkVal("rst irq", 32'(irq_btn_o), 32'd0);
    checkVal("rst lock_lost", 32'(lock_lost_o), 32'd0);
    modelReset();
    @(posedge clk_i);
    @(negedge clk_i);
    arst_ni = 1'b1;
  endtask

  initial begin
    int pulses, firstAt;
    arst_ni      = 1'b0;
    pll_locked_i = 1'b0;
    btn_i        = 1'b0;
    modelReset();
    repeat (3) @(negedge clk_i);
    pulseReset();

    // Glitch in STABLE, then clean boot, then lock loss in RUN.
    tbl.push_back('{1'b1, 1'b0, 5, 2'd1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2, 2'd1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1, 2'd0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3, 2'd0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 2, 2'd0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1, 2'd1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 7, 2'd1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1, 2'd2, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 3, 2'd2, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1, 2'd3, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 5, 2'd3, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2, 2'd3, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1, 2'd0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 3, 2'd0, 1'b1, 1'b1, 1'b1});
    foreach (tbl[v]) begin
      repeat (tbl[v].steps) applyStimulus(tbl[v].lock, tbl[v].btn);
      checkVal($sformatf("vec%0d state", v), 32'(state_o), 32'(tbl[v].st));
      checkVal($sformatf("vec%0d periph", v), 32'(periph_arst_o), 32'(tbl[v].periph));
      checkVal($sformatf("vec%0d cpu", v), 32'(cpu_arst_o), 32'(tbl[v].cpu));
      checkVal($sformatf("vec%0d lost", v), 32'(lock_lost_o), 32'(tbl[v].lost));
    end
    pulseReset();

    // Debounce in RUN: press, release, bounce, short release.
    runSeq(1'b1, 1'b0, 16, pulses, firstAt);
    checkVal("boot to run", 32'(state_o), 32'd3);
    runSeq(1'b1, 1'b1, 10, pulses, firstAt);
    checkVal("press pulses", 32'(pulses), 32'd1);
    checkVal("press pulse step", 32'(firstAt), 32'd7);
    runSeq(1'b1, 1'b0, 10, pulses, firstAt);
    checkVal("release pulses", 32'(pulses), 32'd0);
    runSeq(1'b1, 1'b1, 3, pulses, firstAt);
    checkVal("bounce pulses", 32'(pulses), 32'd0);
    runSeq(1'b1, 1'b0, 10, pulses, firstAt);
    checkVal("bounce tail pulses", 32'(pulses), 32'd0);
    runSeq(1'b1, 1'b1, 10, pulses, firstAt);
    checkVal("second press pulses", 32'(pulses), 32'd1);
    runSeq(1'b1, 1'b0, 5, pulses, firstAt);
    checkVal("short release pulses", 32'(pulses), 32'd0);
    runSeq(1'b1, 1'b0, 5, pulses, firstAt);
    checkVal("short release tail", 32'(pulses), 32'd0);

    // Press whose debounced edge lands in PERIPH never interrupts.
    pulseReset();
    runSeq(1'b1, 1'b0, 5, pulses, firstAt);
    runSeq(1'b1, 1'b1, 20, pulses, firstAt);
    checkVal("periph press pulses", 32'(pulses), 32'd0);
    checkVal("periph press state", 32'(state_o), 32'd3);

    // Reset in the middle of PERIPH restarts the whole sequence.
    pulseReset();
    runSeq(1'b1, 1'b0, 12, pulses, firstAt);
    checkVal("mid periph state", 32'(state_o), 32'd2);
    pulseReset();
    runSeq(1'b1, 1'b0, 10, pulses, firstAt);
    checkVal("restart stable", 32'(state_o), 32'd1);
    checkVal("restart periph held", 32'(periph_arst_o), 32'd1);
    runSeq(1'b1, 1'b0, 1, pulses, firstAt);
    checkVal("restart periph", 32'(state_o), 32'd2);
    runSeq(1'b1, 1'b0, 4, pulses, firstAt);
    checkVal("restart run", 32'(state_o), 32'd3);
    checkVal("restart cpu", 32'(cpu_arst_o), 32'd0);

    // Randomized runs of lock/button levels with occasional resets.
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 19) == 0) begin
        pulseReset();
      end else begin
        runSeq(($urandom_range(0, 5) != 0), $urandom_range(0, 1) == 1,
               int'($urandom_range(1, 30)), pulses, firstAt);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
